rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Owns the single register-file write port: merges in-order WB-stage writes with out-of-order
//  completions from a long-latency unit (LLU: mul/div/load-miss) buffered in a 2-entry FIFO.
//  Keeps a 32-bit busy scoreboard of LLU destinations and raises a decode-stage stall on RAW/WAW hazards.
//  Drives RegWrite/rd_addr/write_data of the RF; sits between WB stage, LLU and RF.
// PARAMETERS
//  n          32  data width, equal to the RF word width
//  STARVE_MAX 4   consecutive cycles a non-empty FIFO may lose the port to WB before LLU is forced
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   asynchronous, active-high reset
//  wb_valid       in   1   WB stage has a write this cycle
//  wb_rd          in   5   WB destination register
//  wb_data        in   n   WB write data
//  wb_stall       out  1   WB write NOT taken this cycle; pipeline must hold WB stage unchanged
//  llu_issue      in   1   LLU op dispatched this cycle
//  llu_issue_rd   in   5   destination of dispatched LLU op
//  llu_issue_rdy  out  1   dispatch allowed (llu_issue_rd not busy); llu_issue ignored when 0
//  llu_valid      in   1   LLU result available
//  llu_rd         in   5   LLU result destination
//  llu_data       in   n   LLU result data
//  llu_ready      out  1   FIFO can accept; transfer when llu_valid && llu_ready
//  rs1_addr       in   5   decode source 1
//  rs2_addr       in   5   decode source 2
//  dec_rd         in   5   decode destination (WAW check)
//  hz_stall       out  1   decode must stall
//  RegWrite       out  1   RF write enable
//  rd_addr        out  5   RF write address
//  write_data     out  n   RF write data
// BEHAVIOUR
//  - Reset (async): FIFO empty, busy[31:0]=0, starve count=0; while rst=1 RegWrite=0, wb_stall=0,
//    llu_ready=0, hz_stall=0, llu_issue_rdy=0, rd_addr=0, write_data=0.
//  - Grant (combinational, same cycle): force = fifo_nonempty && cnt==STARVE_MAX.
//    force -> FIFO head wins, wb_stall=wb_valid. else wb_valid -> WB wins, wb_stall=0.
//    else fifo_nonempty -> FIFO head wins. else no grant, RegWrite=0.
//  - Winner drives rd_addr/write_data; RegWrite=1 only if winner rd!=0. Writes to x0 are still
//    consumed (WB accepted / FIFO popped) but never reach the RF.
//  - FIFO: 2 entries {rd,data}; llu_ready = !full; push and pop in the same cycle legal when full
//    only if pop happens (llu_ready stays registered-full-based: full -> llu_ready=0 regardless).
//    Order strictly FIFO. Empty: no pop. Overflow impossible by handshake.
//  - Starve counter: increments when fifo_nonempty && WB wins; clears on any FIFO pop or when
//    FIFO empty; saturates at STARVE_MAX. Guarantees LLU write within STARVE_MAX+1 cycles.
//  - Scoreboard: llu_issue_rdy = !busy[llu_issue_rd] || llu_issue_rd==0.
//    Set busy[rd] on llu_issue && llu_issue_rdy && rd!=0. Clear busy[rd] on FIFO pop of rd.
//    Set and clear of same reg in one cycle cannot occur (set requires busy=0). busy[0] always 0.
//  - hz_stall = (rs1_addr!=0 && busy[rs1_addr]) || (rs2_addr!=0 && busy[rs2_addr])
//               || (dec_rd!=0 && busy[dec_rd]). No bypass from the write port in the same cycle.
//  - WB write to a busy rd: performed, busy unchanged (hz_stall prevents this in legal flows).
//  - Reset mid-operation: all FIFO contents and busy bits discarded; no RF write during or after.
// STRUCTURE
//  - Shared package rf_ctrl_pkg: REG_ADDR_W=5, NUM_REGS=32, grant encoding GNT_NONE/GNT_WB/GNT_LLU,
//    STARVE_CNT_W function of STARVE_MAX.
//  - One sub-module: rf_llu_fifo (2-entry, 1-bit pointers + count, async reset). Grant, counter and
//    scoreboard in this module.
// TESTING
//  1 WB only: wb_valid, wb_rd=5, data=0xDEADBEEF -> same cycle RegWrite=1, rd_addr=5, wb_stall=0.
//  2 x0: wb_rd=0 -> RegWrite=0, wb_stall=0; LLU result rd=0 -> popped, RegWrite=0, busy unchanged.
//  3 Scoreboard: issue rd=7 -> busy[7]=1; rs1_addr=7 -> hz_stall=1; LLU result rd=7 written with no
//    WB -> next cycle busy[7]=0, hz_stall=0; re-issue rd=7 while busy -> llu_issue_rdy=0.
//  4 Starvation: FIFO holds rd=9, wb_valid held 1 -> WB wins 4 cycles, 5th cycle rd_addr=9,
//    wb_stall=1; next cycle held WB write lands, wb_stall=0.
//  5 FIFO full: two LLU results pushed under continuous WB -> llu_ready=0; results drain in push order.
//  6 Reset mid-op: rst pulse with FIFO 2-full and busy[3]=1 -> all outputs 0 immediately, busy cleared,
//    no stale write after release.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rf_ctrl_pkg
//   Shared definitions for the register-file write-port control slice:
//   register address geometry, the write-port grant encoding, LLU FIFO depth
//   and the width helper for the anti-starvation counter.
// ---------------------------------------------------------------------------
package rf_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int FIFO_DEPTH = 2;

    // Which requester owns the RF write port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_LLU  = 2'd2
    } grant_e;

    // Bits needed to hold 0..max_count inclusive (at least one bit).
    function automatic int starve_cnt_w(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int STARVE_CNT_W       = starve_cnt_w(STARVE_MAX_DEFAULT);

endpackage

// File: rtl/rf_llu_fifo.sv
// ---------------------------------------------------------------------------
// rf_llu_fifo
//   Two-entry FIFO buffering {rd, data} results from the long-latency unit
//   until they win the register-file write port.
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   push, push_rd,     enqueue request and payload (ignored when full)
//   push_data
//   pop                dequeue request (ignored when empty)
//   full, empty        occupancy flags, derived from the registered count
//   head_rd, head_data oldest entry
// ---------------------------------------------------------------------------
module rf_llu_fifo
    import rf_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [W-1:0]          push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [REG_ADDR_W-1:0] head_rd,
    output logic [W-1:0]          head_data
);

    logic [REG_ADDR_W-1:0] rd_q   [FIFO_DEPTH];
    logic [W-1:0]          data_q [FIFO_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_rd   = rd_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                rd_q[wr_ptr]   <= push_rd;
                data_q[wr_ptr] <= push_data;
                wr_ptr         <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//   Owns the single register-file write port. Merges in-order WB writes with
//   out-of-order long-latency-unit (LLU) completions held in a 2-entry FIFO,
//   tracks outstanding LLU destinations in a busy scoreboard and raises the
//   decode-stage hazard stall.
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   wb_valid, wb_rd, wb_data      WB-stage write request
//   wb_stall                      WB write not taken; hold the WB stage
//   llu_issue, llu_issue_rd       LLU dispatch and its destination
//   llu_issue_rdy                 dispatch allowed (destination not busy)
//   llu_valid, llu_rd, llu_data   LLU result, accepted when llu_ready
//   llu_ready                     FIFO has room
//   rs1_addr, rs2_addr, dec_rd    decode operands for RAW/WAW checks
//   hz_stall                      decode must stall
//   RegWrite, rd_addr, write_data RF write port
// ---------------------------------------------------------------------------
module rf_write_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int n          = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [n-1:0]          wb_data,
    output logic                  wb_stall,
    input  logic                  llu_issue,
    input  logic [REG_ADDR_W-1:0] llu_issue_rd,
    output logic                  llu_issue_rdy,
    input  logic                  llu_valid,
    input  logic [REG_ADDR_W-1:0] llu_rd,
    input  logic [n-1:0]          llu_data,
    output logic                  llu_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    output logic                  hz_stall,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [n-1:0]          write_data
);

    localparam int                CNT_W   = starve_cnt_w(STARVE_MAX);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_nonempty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [n-1:0]          head_data;

    grant_e                grant;
    logic [CNT_W-1:0]      starve_cnt;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   set_mask;
    logic [NUM_REGS-1:0]   clr_mask;
    logic                  issue_ok;

    rf_llu_fifo #(
        .W (n)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_rd   (llu_rd),
        .push_data (llu_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_rd   (head_rd),
        .head_data (head_data)
    );

    assign fifo_nonempty = !fifo_empty;

    // Starvation forcing beats WB; otherwise WB has priority over the FIFO.
    // Holding rst suppresses every grant so nothing reaches the RF.
    always_comb begin
        grant = GNT_NONE;
        if (fifo_nonempty && (starve_cnt == CNT_MAX)) begin
            grant = GNT_LLU;
        end else if (wb_valid) begin
            grant = GNT_WB;
        end else if (fifo_nonempty) begin
            grant = GNT_LLU;
        end
        if (rst) begin
            grant = GNT_NONE;
        end
    end

    // x0 writes are still consumed by the winner but never enable the RF.
    always_comb begin
        rd_addr    = '0;
        write_data = '0;
        case (grant)
            GNT_WB: begin
                rd_addr    = wb_rd;
                write_data = wb_data;
            end
            GNT_LLU: begin
                rd_addr    = head_rd;
                write_data = head_data;
            end
            default: begin
                rd_addr    = '0;
                write_data = '0;
            end
        endcase
    end

    assign RegWrite  = (grant != GNT_NONE) && (rd_addr != '0);
    assign wb_stall  = wb_valid && (grant != GNT_WB) && !rst;
    assign fifo_pop  = (grant == GNT_LLU);
    assign llu_ready = !fifo_full && !rst;
    assign fifo_push = llu_valid && llu_ready;

    assign llu_issue_rdy = (!busy[llu_issue_rd] || (llu_issue_rd == '0)) && !rst;
    assign issue_ok      = llu_issue && llu_issue_rdy && (llu_issue_rd != '0);

    assign hz_stall = !rst &&
                      (((rs1_addr != '0) && busy[rs1_addr]) ||
                       ((rs2_addr != '0) && busy[rs2_addr]) ||
                       ((dec_rd   != '0) && busy[dec_rd]));

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_ok) begin
            set_mask[llu_issue_rd] = 1'b1;
        end
        if (fifo_pop) begin
            clr_mask[head_rd] = 1'b1;
        end
    end

    // Counts cycles the non-empty FIFO lost to WB; any pop or an empty FIFO
    // restarts the count, and it saturates where forcing kicks in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
        end else if ((grant == GNT_WB) && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Set and clear never collide on one register because setting requires
    // the bit to be clear already. Bit 0 is kept permanently clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        llu_issue;
    logic [4:0]  llu_issue_rd;
    logic        llu_issue_rdy;
    logic        llu_valid;
    logic [4:0]  llu_rd;
    logic [31:0] llu_data;
    logic        llu_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  dec_rd;
    logic        hz_stall;
    logic        RegWrite;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;

    int checkCount;
    int errorCount;

    rf_write_arbiter #(
        .n          (32),
        .STARVE_MAX (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_stall      (wb_stall),
        .llu_issue     (llu_issue),
        .llu_issue_rd  (llu_issue_rd),
        .llu_issue_rdy (llu_issue_rdy),
        .llu_valid     (llu_valid),
        .llu_rd        (llu_rd),
        .llu_data      (llu_data),
        .llu_ready     (llu_ready),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .dec_rd        (dec_rd),
        .hz_stall      (hz_stall),
        .RegWrite      (RegWrite),
        .rd_addr       (rd_addr),
        .write_data    (write_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of run, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Drive WB and LLU-result inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic wbv, input logic [4:0] wbr, input logic [31:0] wbd,
                                 input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        wb_valid = wbv;
        wb_rd    = wbr;
        wb_data  = wbd;
        llu_valid = lv;
        llu_rd    = lr;
        llu_data  = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checkCount   = 0;
        errorCount   = 0;
        rst          = 1'b0;
        llu_issue    = 1'b0;
        llu_issue_rd = 5'd0;
        rs1_addr     = 5'd0;
        rs2_addr     = 5'd0;
        dec_rd       = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2 rst = 1'b1;

        // Reset: outputs held low even with a WB request present
        @(negedge clk);
        applyStimulus(1'b1, 5'd5, 32'h1111_2222, 1'b0, 5'd0, 32'h0);
        checkFlag("rst_regwrite", RegWrite, 1'b0);
        checkFlag("rst_wb_stall", wb_stall, 1'b0);
        checkFlag("rst_llu_ready", llu_ready, 1'b0);
        checkFlag("rst_issue_rdy", llu_issue_rdy, 1'b0);
        checkFlag("rst_hz_stall", hz_stall, 1'b0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("rst_write_data", write_data, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        // 1: WB only
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
        checkFlag("wb_regwrite", RegWrite, 1'b1);
        checkOutput("wb_rd_addr", 32'(rd_addr), 32'd5);
        checkOutput("wb_write_data", write_data, 32'hDEAD_BEEF);
        checkFlag("wb_no_stall", wb_stall, 1'b0);
        tick();

        // 2: x0 writes from WB and from the LLU
        applyStimulus(1'b1, 5'd0, 32'h5555_AAAA, 1'b0, 5'd0, 32'h0);
        checkFlag("x0_wb_regwrite", RegWrite, 1'b0);
        checkFlag("x0_wb_stall", wb_stall, 1'b0);
        tick();
        llu_issue    = 1'b1;
        llu_issue_rd = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_1234);
        checkFlag("x0_issue_rdy", llu_issue_rdy, 1'b1);
        checkFlag("x0_llu_ready", llu_ready, 1'b1);
        tick();
        llu_issue = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkFlag("x0_llu_regwrite", RegWrite, 1'b0);
        checkFlag("x0_llu_issue_rdy_after", llu_issue_rdy, 1'b1);
        tick();
        checkFlag("x0_fifo_drained", RegWrite, 1'b0);
        checkFlag("x0_llu_ready_after", llu_ready, 1'b1);

        // 3: scoreboard set, RAW/WAW stall, clear on write-back
        llu_issue    = 1'b1;
        llu_issue_rd = 5'd7;
        #1;
        checkFlag("sb_issue_rdy_free", llu_issue_rdy, 1'b1);
        tick();
        llu_issue = 1'b0;
        rs1_addr  = 5'd7;
        #1;
        checkFlag("sb_raw_stall", hz_stall, 1'b1);
        checkFlag("sb_reissue_blocked", llu_issue_rdy, 1'b0);
        rs1_addr = 5'd0;
        dec_rd   = 5'd7;
        #1;
        checkFlag("sb_waw_stall", hz_stall, 1'b1);
        dec_rd   = 5'd0;
        rs2_addr = 5'd8;
        #1;
        checkFlag("sb_other_reg_free", hz_stall, 1'b0);
        rs2_addr = 5'd0;
        rs1_addr = 5'd7;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hA5A5_A5A5);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkFlag("sb_llu_regwrite", RegWrite, 1'b1);
        checkOutput("sb_llu_rd_addr", 32'(rd_addr), 32'd7);
        checkOutput("sb_llu_data", write_data, 32'hA5A5_A5A5);
        checkFlag("sb_no_bypass", hz_stall, 1'b1);
        tick();
        checkFlag("sb_cleared_stall", hz_stall, 1'b0);
        checkFlag("sb_issue_rdy_again", llu_issue_rdy, 1'b1);
        rs1_addr = 5'd0;

        // 4: starvation forcing after four lost cycles
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_0099);
        tick();
        applyStimulus(1'b1, 5'd10, 32'h0000_1010, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("starve_wb_win_%0d", i), 32'(rd_addr), 32'd10);
            checkFlag($sformatf("starve_wb_nostall_%0d", i), wb_stall, 1'b0);
            tick();
        end
        checkOutput("starve_forced_rd", 32'(rd_addr), 32'd9);
        checkOutput("starve_forced_data", write_data, 32'h0000_0099);
        checkFlag("starve_wb_stall", wb_stall, 1'b1);
        checkFlag("starve_regwrite", RegWrite, 1'b1);
        tick();
        checkOutput("starve_wb_lands_rd", 32'(rd_addr), 32'd10);
        checkOutput("starve_wb_lands_data", write_data, 32'h0000_1010);
        checkFlag("starve_wb_unstall", wb_stall, 1'b0);
        tick();

        // 5: FIFO fills under continuous WB, then drains in push order
        applyStimulus(1'b1, 5'd11, 32'h0000_00B0, 1'b1, 5'd12, 32'h0000_00C1);
        checkFlag("full_ready_empty", llu_ready, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd11, 32'h0000_00B0, 1'b1, 5'd13, 32'h0000_00C2);
        checkFlag("full_ready_one", llu_ready, 1'b1);
        checkOutput("full_wb_wins", 32'(rd_addr), 32'd11);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkFlag("full_not_ready", llu_ready, 1'b0);
        checkOutput("drain_first_rd", 32'(rd_addr), 32'd12);
        checkOutput("drain_first_data", write_data, 32'h0000_00C1);
        tick();
        checkOutput("drain_second_rd", 32'(rd_addr), 32'd13);
        checkOutput("drain_second_data", write_data, 32'h0000_00C2);
        checkFlag("drain_ready_again", llu_ready, 1'b1);
        tick();
        checkFlag("drain_empty_idle", RegWrite, 1'b0);

        // 6: reset mid-operation with a full FIFO and busy[3] set
        llu_issue    = 1'b1;
        llu_issue_rd = 5'd3;
        applyStimulus(1'b1, 5'd1, 32'h0000_0001, 1'b1, 5'd20, 32'h0000_0020);
        tick();
        llu_issue = 1'b0;
        applyStimulus(1'b1, 5'd1, 32'h0000_0001, 1'b1, 5'd21, 32'h0000_0021);
        tick();
        applyStimulus(1'b1, 5'd1, 32'h0000_0001, 1'b0, 5'd0, 32'h0);
        rs1_addr = 5'd3;
        #1;
        checkFlag("pre_rst_busy3", hz_stall, 1'b1);
        checkFlag("pre_rst_full", llu_ready, 1'b0);
        rst = 1'b1;
        #1;
        checkFlag("mid_rst_regwrite", RegWrite, 1'b0);
        checkFlag("mid_rst_wb_stall", wb_stall, 1'b0);
        checkFlag("mid_rst_llu_ready", llu_ready, 1'b0);
        checkFlag("mid_rst_hz_stall", hz_stall, 1'b0);
        checkOutput("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("mid_rst_write_data", write_data, 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkFlag("post_rst_busy_cleared", hz_stall, 1'b0);
        checkFlag("post_rst_no_write", RegWrite, 1'b0);
        checkFlag("post_rst_ready", llu_ready, 1'b1);
        checkFlag("post_rst_issue_rdy", llu_issue_rdy, 1'b1);
        tick();
        checkFlag("post_rst_no_stale", RegWrite, 1'b0);
        rs1_addr = 5'd0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
